// File: rtl/uart_rx_top.sv
// UART receiver: oversamples RX_IN, majority-votes the bit centres, deserialises LSB-first,
// then checks optional parity and stop bit and reports one-cycle valid/error pulses.
module uart_rx_top #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int BW = $clog2(DATA_WIDTH + 3);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [5:0]              edge_cnt_reg;
    logic [BW-1:0]           bit_cnt_reg;
    logic [5:0]              prescale_reg;
    logic                    par_en_reg, par_typ_reg;
    logic                    samp_a_reg, samp_b_reg;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    par_bad_reg;
    logic [DATA_WIDTH-1:0]   p_data_reg;
    logic                    data_valid_reg, par_err_reg, stp_err_reg;

    logic [5:0]              half;
    logic                    bit_end, at_samp_a, at_samp_b, at_last;
    logic                    vote_now, last_data;
    logic [DATA_WIDTH-1:0]   bit_sel;

    assign half      = {1'b0, prescale_reg[5:1]};
    assign bit_end   = (edge_cnt_reg == prescale_reg - 6'd1);
    assign at_samp_a = (edge_cnt_reg == half - 6'd1);
    assign at_samp_b = (edge_cnt_reg == half);
    assign at_last   = (edge_cnt_reg == half + 6'd1);
    assign last_data = (bit_cnt_reg == BW'(DATA_WIDTH));

    // The third sample is taken live so every decision lands on the cycle the vote completes.
    assign vote_now  = (samp_a_reg & samp_b_reg) | (samp_a_reg & RX_IN) | (samp_b_reg & RX_IN);

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_sel
            assign bit_sel[gi] = (bit_cnt_reg == BW'(gi + 1));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!RX_IN) state_next = START;
            START: begin
                if (at_last && vote_now) state_next = IDLE;
                else if (bit_end)        state_next = DATA;
            end
            DATA:    if (bit_end && last_data) state_next = par_en_reg ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (at_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            prescale_reg <= 6'd8;
            par_en_reg   <= 1'b0;
            par_typ_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                bit_cnt_reg  <= '0;
                edge_cnt_reg <= RX_IN ? 6'd0 : 6'd1;
                if (!RX_IN) begin
                    prescale_reg <= (PRESCALE == 6'd16 || PRESCALE == 6'd32) ? PRESCALE : 6'd8;
                    par_en_reg   <= PAR_EN;
                    par_typ_reg  <= PAR_TYP;
                end
            end else if (state_next == IDLE) begin
                edge_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
            end else if (bit_end) begin
                edge_cnt_reg <= '0;
                bit_cnt_reg  <= bit_cnt_reg + 1'b1;
            end else begin
                edge_cnt_reg <= edge_cnt_reg + 6'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_a_reg     <= 1'b1;
            samp_b_reg     <= 1'b1;
            shift_reg      <= '0;
            par_bad_reg    <= 1'b0;
            p_data_reg     <= '0;
            data_valid_reg <= 1'b0;
            par_err_reg    <= 1'b0;
            stp_err_reg    <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            par_err_reg    <= 1'b0;
            stp_err_reg    <= 1'b0;
            if (state_reg != IDLE && at_samp_a) samp_a_reg <= RX_IN;
            if (state_reg != IDLE && at_samp_b) samp_b_reg <= RX_IN;
            if (state_reg == IDLE) par_bad_reg <= 1'b0;
            if (state_reg == DATA && at_last) begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (bit_sel[i]) shift_reg[i] <= vote_now;
                end
            end
            if (state_reg == PARITY && at_last)
                par_bad_reg <= vote_now != ((^shift_reg) ^ par_typ_reg);
            if (state_reg == STOP && at_last) begin
                if (!par_bad_reg && vote_now) begin
                    data_valid_reg <= 1'b1;
                    p_data_reg     <= shift_reg;
                end else begin
                    par_err_reg <= par_bad_reg;
                    stp_err_reg <= !vote_now;
                end
            end
        end
    end

    assign P_DATA     = p_data_reg;
    assign DATA_VALID = data_valid_reg;
    assign PAR_ERR    = par_err_reg;
    assign STP_ERR    = stp_err_reg;

endmodule

// File: tb/tb_uart_rx_top.sv
// Scoreboard bench for uart_rx_top: directed frames push expected pulses,
// a negedge monitor pops and compares flags, P_DATA and arrival cycle.
module tb_uart_rx_top;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       DATA_VALID, PAR_ERR, STP_ERR;

    uart_rx_top #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] flags;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected entry.
    always @(negedge CLK) begin
        if (RST && (DATA_VALID || PAR_ERR || STP_ERR)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_pulse: got flags %b at cycle %0d, expected none",
                         {DATA_VALID, PAR_ERR, STP_ERR}, cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("[TB] pulse dv/pe/se=%b p_data=0x%02h cycle=%0d", {DATA_VALID, PAR_ERR, STP_ERR}, P_DATA, cyc);
                check("flags", int'({DATA_VALID, PAR_ERR, STP_ERR}), int'(mon_e.flags));
                check("p_data", int'(P_DATA), int'(mon_e.data));
                check("cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Called at posedge+1; the first cycle of the start bit is S0.
    task automatic send_frame(input logic [7:0] data, input int p, input logic [5:0] presc,
                              input logic pen, input logic ptyp, input logic pbit,
                              input logic stopbit, input int gbit, input int gedge,
                              input logic [2:0] flags, input logic [7:0] exp_data);
        logic [10:0] bits;
        int nb;
        int s0;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = data;
        if (pen) begin
            bits[9] = pbit;
            bits[10] = stopbit;
            nb = 11;
        end else begin
            bits[9] = stopbit;
            nb = 10;
        end
        PRESCALE = presc;
        PAR_EN = pen;
        PAR_TYP = ptyp;
        s0 = cyc;
        sb.push_back('{flags, exp_data, s0 + (nb - 1) * p + p / 2 + 2});
        for (int b = 0; b < nb; b++) begin
            for (int e = 0; e < p; e++) begin
                RX_IN = (b == gbit && e == gedge) ? ~bits[b] : bits[b];
                if (b == 0 && e == 1) begin
                    PRESCALE = (presc == 6'd16) ? 6'd32 : 6'd16;
                    PAR_EN = ~pen;
                    PAR_TYP = ~ptyp;
                end
                @(posedge CLK);
                #1;
            end
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] pbits;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_p_data", int'(P_DATA), 0);
        check("reset_data_valid", int'(DATA_VALID), 0);
        check("reset_par_err", int'(PAR_ERR), 0);
        check("reset_stp_err", int'(STP_ERR), 0);
        RST = 1'b1;
        idle(3);

        // 0xA5, P=8, no parity -> valid at S0+78
        send_frame(8'hA5, 8, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 3'b100, 8'hA5);
        // 0x3C, P=16, even parity, correct parity bit 0 -> valid at S0+170
        send_frame(8'h3C, 16, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, 3'b100, 8'h3C);
        // same with wrong parity bit -> PAR_ERR, P_DATA stays 0x3C
        send_frame(8'h3C, 16, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 3'b010, 8'h3C);
        // 0x01, P=8, odd parity (bit 0 correct), stop 0 -> STP_ERR at S0+86
        send_frame(8'h01, 8, 6'd8, 1'b1, 1'b1, 1'b0, 1'b0, -1, 0, 3'b001, 8'h3C);
        idle(40);
        // parity and stop both wrong -> both pulses together
        send_frame(8'h3C, 16, 6'd16, 1'b1, 1'b0, 1'b1, 1'b0, -1, 0, 3'b011, 8'h3C);
        idle(40);

        // start glitch: 2 low cycles, then a frame must be accepted from S0+6
        PRESCALE = 6'd8;
        RX_IN = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        idle(4);
        // illegal prescale 10 behaves as 8
        send_frame(8'h96, 8, 6'd10, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 3'b100, 8'h96);

        // single-sample glitch at the centre of data bit 3
        send_frame(8'h55, 8, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 4, 4, 3'b100, 8'h55);

        // back-to-back at P=32, second frame cut by reset
        send_frame(8'h12, 32, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 3'b100, 8'h12);
        pbits = {2'b11, 8'h34, 1'b0};
        PRESCALE = 6'd32;
        PAR_EN = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int e = 0; e < 32; e++) begin
                RX_IN = pbits[b];
                @(posedge CLK);
                #1;
            end
        end
        RST = 1'b0;
        #1;
        check("midreset_p_data", int'(P_DATA), 0);
        check("midreset_data_valid", int'(DATA_VALID), 0);
        check("midreset_par_err", int'(PAR_ERR), 0);
        check("midreset_stp_err", int'(STP_ERR), 0);
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(400);
        check("post_reset_p_data", int'(P_DATA), 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
